frc_burst_unpacker: RTL and testbench

//  Receive side of the inter-FPGA force path. Accepts 512-bit force bursts from the network RX AXIS
//  (format produced by the TX burst controller), buffers them, and emits one 128-bit force sub-packet
//  per cycle to the local force accumulation, skipping empty slots. Detects the end-of-transfer flag
//  and pulses a completion strobe once the final burst has fully drained.

---
 rtl/MD_pkg.sv | 28 ++
 rtl/frc_burst_fifo.sv | 52 +++++
 rtl/frc_burst_unpacker.sv | 184 ++++++++++++++++++
 tb/tb_frc_burst_unpacker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/MD_pkg.sv
// Shared widths, burst layout and FSM state type for the force burst unpacker.
package MD_pkg;

  localparam int AXIS_TDATA_WIDTH = 512;
  localparam int SUB_PACKET_WIDTH = 128;
  localparam int NUM_SUB_PACKETS  = AXIS_TDATA_WIDTH / SUB_PACKET_WIDTH;
  localparam int NODE_ID_WIDTH    = 8;
  localparam int SLOT_IDX_WIDTH   = $clog2(NUM_SUB_PACKETS);

  typedef logic [NUM_SUB_PACKETS-1:0][SUB_PACKET_WIDTH-1:0] frc_burst_t;
  typedef logic [NUM_SUB_PACKETS-1:0]                       slot_mask_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } unpack_state_t;

  // Slot 3 is the oldest, so the highest set bit is always emitted first.
  function automatic logic [SLOT_IDX_WIDTH-1:0] highest_slot(input slot_mask_t m);
    logic [SLOT_IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_SUB_PACKETS; k++) begin
      if (m[k]) idx = SLOT_IDX_WIDTH'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/frc_burst_fifo.sv
// Synchronous FIFO holding received bursts plus their source id.
// Pointers carry an extra MSB so full and empty come straight from registers.
module frc_burst_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/frc_burst_unpacker.sv
// Receive-side force burst unpacker: buffers 512-bit bursts and serializes the
// non-empty 128-bit slots. Optional debug counters: FRC_UNPACK_DEBUG_CNT_EN.
module frc_burst_unpacker
  import MD_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int LAST_FLAG_BIT = 96,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_frc_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] i_frc_tdata,
  input  logic [NODE_ID_WIDTH-1:0]    i_src_id,
  output logic                        o_frc_tready,
  output logic                        o_frc_valid,
  input  logic                        i_frc_ready,
  output logic [SUB_PACKET_WIDTH-1:0] o_frc_pkt,
  output logic [NODE_ID_WIDTH-1:0]    o_frc_src_id,
  output logic                        o_frc_last,
`ifdef FRC_UNPACK_DEBUG_CNT_EN
  output logic [CNT_WIDTH-1:0]        o_burst_cnt,
  output logic [CNT_WIDTH-1:0]        o_pkt_cnt,
`endif
  output logic                        o_last_frc_received
);

  localparam int FIFO_WIDTH = AXIS_TDATA_WIDTH + NODE_ID_WIDTH;

  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_WIDTH-1:0]    fifo_head;
  frc_burst_t               head_burst;
  logic [NODE_ID_WIDTH-1:0] head_src;

  unpack_state_t                   state_q, state_d;
  slot_mask_t                      mask_q, mask_d;
  frc_burst_t                      data_q, data_d;
  logic [NODE_ID_WIDTH-1:0]        src_q, src_d;
  logic                            flag_q, flag_d;
  logic                            done_q, done_d;
  logic                            valid_q, valid_d;
  logic                            last_q, last_d;
  logic [SUB_PACKET_WIDTH-1:0]     pkt_q, pkt_d;
  logic                            load;
  logic [SLOT_IDX_WIDTH-1:0]       cur_slot, next_slot;

  function automatic slot_mask_t slot_mask(input frc_burst_t b);
    slot_mask_t                  m;
    logic [SUB_PACKET_WIDTH-1:0] s;
    for (int k = 0; k < NUM_SUB_PACKETS; k++) begin
      s = b[k];
      s[LAST_FLAG_BIT] = 1'b0;
      m[k] = |s;
    end
    return m;
  endfunction

  assign o_frc_tready = !fifo_full;
  assign fifo_push    = i_frc_tvalid && !fifo_full;
  assign head_burst   = frc_burst_t'(fifo_head[AXIS_TDATA_WIDTH-1:0]);
  assign head_src     = fifo_head[FIFO_WIDTH-1:AXIS_TDATA_WIDTH];

  frc_burst_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({i_src_id, i_frc_tdata}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cur_slot = highest_slot(mask_q);

  // Next-state logic; a burst finishing in DRAIN may hand over to the next one with no gap.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    data_d   = data_q;
    src_d    = src_q;
    flag_d   = flag_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      DRAIN: begin
        if (i_frc_ready) begin
          mask_d[cur_slot] = 1'b0;
          if (mask_d == '0) begin
            done_d = flag_q;
            if (!fifo_empty) load = 1'b1;
            else             state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      data_d   = head_burst;
      src_d    = head_src;
      flag_d   = head_burst[0][LAST_FLAG_BIT];
      mask_d   = slot_mask(head_burst);
      if (mask_d == '0) begin
        state_d = IDLE;
        done_d  = done_d | flag_d;
      end else begin
        state_d = DRAIN;
      end
    end

    next_slot = highest_slot(mask_d);
    pkt_d     = '0;
    if (mask_d != '0) begin
      pkt_d = data_d[next_slot];
      pkt_d[LAST_FLAG_BIT] = 1'b0;
    end
    valid_d = (state_d == DRAIN);
    last_d  = valid_d && flag_d && ($countones(mask_d) == 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      data_q  <= '0;
      src_q   <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      src_q   <= src_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
    end
  end

  assign o_frc_valid         = valid_q;
  assign o_frc_pkt           = pkt_q;
  assign o_frc_src_id        = src_q;
  assign o_frc_last          = last_q;
  assign o_last_frc_received = done_q;

`ifdef FRC_UNPACK_DEBUG_CNT_EN
  logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    burst_cnt_d = burst_cnt_q + CNT_WIDTH'(fifo_push);
    pkt_cnt_d   = pkt_cnt_q + CNT_WIDTH'(valid_q && i_frc_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt_q <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign o_burst_cnt = burst_cnt_q;
  assign o_pkt_cnt   = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_frc_burst_unpacker.sv
// Directed self-checking bench for frc_burst_unpacker (default build).
module tb_frc_burst_unpacker;
  import MD_pkg::*;

  logic                        clk;
  logic                        rst;
  logic                        i_frc_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] i_frc_tdata;
  logic [NODE_ID_WIDTH-1:0]    i_src_id;
  logic                        o_frc_tready;
  logic                        o_frc_valid;
  logic                        i_frc_ready;
  logic [SUB_PACKET_WIDTH-1:0] o_frc_pkt;
  logic [NODE_ID_WIDTH-1:0]    o_frc_src_id;
  logic                        o_frc_last;
  logic                        o_last_frc_received;
`ifdef FRC_UNPACK_DEBUG_CNT_EN
  logic [31:0]                 o_burst_cnt;
  logic [31:0]                 o_pkt_cnt;
`endif

  int assertCount = 0;
  int failCount   = 0;

  frc_burst_unpacker dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_frc_tvalid        (i_frc_tvalid),
    .i_frc_tdata         (i_frc_tdata),
    .i_src_id            (i_src_id),
    .o_frc_tready        (o_frc_tready),
    .o_frc_valid         (o_frc_valid),
    .i_frc_ready         (i_frc_ready),
    .o_frc_pkt           (o_frc_pkt),
    .o_frc_src_id        (o_frc_src_id),
    .o_frc_last          (o_frc_last),
`ifdef FRC_UNPACK_DEBUG_CNT_EN
    .o_burst_cnt         (o_burst_cnt),
    .o_pkt_cnt           (o_pkt_cnt),
`endif
    .o_last_frc_received (o_last_frc_received)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Nonzero slot value whose bit 96 is always 0.
  function automatic logic [127:0] mkSlot(input logic [7:0] seed);
    return {seed, 24'hC0FFEE, 24'h000000, seed, 64'h0123_4567_89AB_CDEF};
  endfunction

  // Drives one burst and returns in the cycle right after it was accepted.
  task automatic applyStimulus(input logic [511:0] data, input logic [7:0] src);
    logic accepted;
    int   budget;
    i_frc_tvalid = 1'b1;
    i_frc_tdata  = data;
    i_src_id     = src;
    budget       = 0;
    accepted     = 1'b0;
    while (!accepted && budget < 50) begin
      accepted = o_frc_tready;
      step();
      budget++;
    end
    if (!accepted) checkOutput("accept_timeout", 128'd0, 128'd1);
    i_frc_tvalid = 1'b0;
    i_frc_tdata  = '0;
    i_src_id     = '0;
  endtask

  logic [127:0] expQ [$];
  logic [127:0] flagBit;
  logic [127:0] slotF;
  int           idx;
  int           cyc;

  initial begin
    flagBit      = 128'd1 << 96;
    rst          = 1'b1;
    i_frc_tvalid = 1'b0;
    i_frc_tdata  = '0;
    i_src_id     = '0;
    i_frc_ready  = 1'b1;
    #2;
    checkOutput("reset_tready", 128'(o_frc_tready), 128'd1);
    checkOutput("reset_valid",  128'(o_frc_valid), 128'd0);
    checkOutput("reset_pkt",    o_frc_pkt, 128'd0);
    checkOutput("reset_last",   128'(o_frc_last), 128'd0);
    checkOutput("reset_done",   128'(o_last_frc_received), 128'd0);
    step();
    step();
    rst = 1'b0;
    step();

    $display("[TB] test 1: full burst");
    applyStimulus({mkSlot(8'hA1), mkSlot(8'hB2), mkSlot(8'hC3), mkSlot(8'hD4)}, 8'h11);
    checkOutput("t1_latency_valid", 128'(o_frc_valid), 128'd0);
    expQ = '{mkSlot(8'hA1), mkSlot(8'hB2), mkSlot(8'hC3), mkSlot(8'hD4)};
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("t1_valid", 128'(o_frc_valid), 128'd1);
      checkOutput("t1_pkt",   o_frc_pkt, expQ[i]);
      checkOutput("t1_src",   128'(o_frc_src_id), 128'h11);
      checkOutput("t1_last",  128'(o_frc_last), 128'd0);
    end
    step();
    checkOutput("t1_end_valid", 128'(o_frc_valid), 128'd0);
    checkOutput("t1_end_done",  128'(o_last_frc_received), 128'd0);

    $display("[TB] test 2: sparse flagged burst");
    slotF = mkSlot(8'hF6) | flagBit;
    applyStimulus({128'd0, 128'd0, mkSlot(8'hE5), slotF}, 8'h22);
    checkOutput("t2_latency_valid", 128'(o_frc_valid), 128'd0);
    step();
    checkOutput("t2_e_valid", 128'(o_frc_valid), 128'd1);
    checkOutput("t2_e_pkt",   o_frc_pkt, mkSlot(8'hE5));
    checkOutput("t2_e_last",  128'(o_frc_last), 128'd0);
    step();
    checkOutput("t2_f_valid", 128'(o_frc_valid), 128'd1);
    checkOutput("t2_f_pkt",   o_frc_pkt, mkSlot(8'hF6));
    checkOutput("t2_f_src",   128'(o_frc_src_id), 128'h22);
    checkOutput("t2_f_last",  128'(o_frc_last), 128'd1);
    checkOutput("t2_f_done",  128'(o_last_frc_received), 128'd0);
    step();
    checkOutput("t2_post_valid", 128'(o_frc_valid), 128'd0);
    checkOutput("t2_done_pulse", 128'(o_last_frc_received), 128'd1);
    step();
    checkOutput("t2_done_clear", 128'(o_last_frc_received), 128'd0);

    $display("[TB] test 3: backpressure and back-to-back drain");
    i_frc_ready = 1'b0;
    expQ.delete();
    for (int b = 0; b < 5; b++) begin
      logic [127:0] s3, s2, s1, s0;
      s3 = mkSlot(8'(8'h30 + b * 4));
      s2 = mkSlot(8'(8'h31 + b * 4));
      s1 = mkSlot(8'(8'h32 + b * 4));
      s0 = mkSlot(8'(8'h33 + b * 4));
      expQ.push_back(s3);
      expQ.push_back(s2);
      expQ.push_back(s1);
      expQ.push_back(s0);
      applyStimulus({s3, s2, s1, s0}, 8'(8'h40 + b));
    end
    checkOutput("t3_tready_full", 128'(o_frc_tready), 128'd0);
    checkOutput("t3_hold_valid",  128'(o_frc_valid), 128'd1);
    checkOutput("t3_hold_pkt",    o_frc_pkt, expQ[0]);
    step();
    checkOutput("t3_hold_pkt2",   o_frc_pkt, expQ[0]);
    i_frc_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checkOutput("t3_valid", 128'(o_frc_valid), 128'd1);
      checkOutput("t3_pkt",   o_frc_pkt, expQ[i]);
      checkOutput("t3_src",   128'(o_frc_src_id), 128'(8'h40 + i / 4));
      step();
    end
    checkOutput("t3_end_valid",  128'(o_frc_valid), 128'd0);
    checkOutput("t3_end_tready", 128'(o_frc_tready), 128'd1);

    $display("[TB] test 4: ready toggling");
    expQ = '{mkSlot(8'h51), mkSlot(8'h52), mkSlot(8'h53), mkSlot(8'h54)};
    applyStimulus({expQ[0], expQ[1], expQ[2], expQ[3]}, 8'h33);
    step();
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 16) begin
      i_frc_ready = ((cyc % 2) == 0);
      checkOutput("t4_valid", 128'(o_frc_valid), 128'd1);
      checkOutput("t4_pkt",   o_frc_pkt, expQ[idx]);
      step();
      if (i_frc_ready) idx++;
      cyc++;
    end
    checkOutput("t4_count", 128'(idx), 128'd4);
    checkOutput("t4_end_valid", 128'(o_frc_valid), 128'd0);
    i_frc_ready = 1'b1;

    $display("[TB] test 5: flag-only burst");
    applyStimulus({128'd0, 128'd0, 128'd0, flagBit}, 8'h44);
    checkOutput("t5_valid_a", 128'(o_frc_valid), 128'd0);
    checkOutput("t5_done_a",  128'(o_last_frc_received), 128'd0);
    step();
    checkOutput("t5_valid_b", 128'(o_frc_valid), 128'd0);
    checkOutput("t5_done_b",  128'(o_last_frc_received), 128'd1);
    step();
    checkOutput("t5_valid_c", 128'(o_frc_valid), 128'd0);
    checkOutput("t5_done_c",  128'(o_last_frc_received), 128'd0);

    $display("[TB] test 6: reset mid-drain");
    i_frc_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      applyStimulus({4{mkSlot(8'(8'h60 + b))}} | {flagBit, 384'd0}, 8'h55);
    end
    checkOutput("t6_pre_valid", 128'(o_frc_valid), 128'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_tready", 128'(o_frc_tready), 128'd1);
    checkOutput("t6_rst_valid",  128'(o_frc_valid), 128'd0);
    checkOutput("t6_rst_pkt",    o_frc_pkt, 128'd0);
    checkOutput("t6_rst_src",    128'(o_frc_src_id), 128'd0);
    step();
    rst = 1'b0;
    i_frc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("t6_no_stale", 128'(o_frc_valid), 128'd0);
      checkOutput("t6_no_done",  128'(o_last_frc_received), 128'd0);
    end
    applyStimulus({mkSlot(8'h71), 128'd0, 128'd0, 128'd0}, 8'h66);
    step();
    checkOutput("t6_fresh_valid", 128'(o_frc_valid), 128'd1);
    checkOutput("t6_fresh_pkt",   o_frc_pkt, mkSlot(8'h71));
    checkOutput("t6_fresh_src",   128'(o_frc_src_id), 128'h66);
    step();
    checkOutput("t6_fresh_end",   128'(o_frc_valid), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
